// File: rtl/led_pattern_ctrl_pkg.sv
// Shared types and constants for the LED pattern engine.
package led_pkg;

   localparam int LED_W_DEFAULT   = 6;
   localparam int DIV_W_DEFAULT   = 16;
   localparam int DIV_RST_DEFAULT = 49999;

   typedef enum logic [1:0] {
      LED_OFF,
      LED_STATIC,
      LED_BLINK,
      LED_CHASE
   } led_mode_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PAT    = 2'd1;
   localparam logic [1:0] ADDR_DIV_LO = 2'd2;
   localparam logic [1:0] ADDR_DIV_HI = 2'd3;

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// Prescaler: counts 0..in_div and emits a one-clock tick at the top of the count.
module led_tick_gen
   import led_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEFAULT
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic [DIV_W-1:0] in_div,
   input  logic             in_clr,
   output logic             out_tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   // A divider rewrite restarts the period, so it must also suppress the tick.
   assign out_tick = (cnt_q == in_div) && !in_clr;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cnt_d = cnt_q + 1'b1;
      if (in_clr || out_tick) begin
         cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Register-mapped LED pattern engine: bus decode, registers, static/blink/chase
// animation and the registered LED output word.
module led_pattern_ctrl
   import led_pkg::*;
#(
   parameter int LED_W   = LED_W_DEFAULT,
   parameter int DIV_W   = DIV_W_DEFAULT,
   parameter int DIV_RST = DIV_RST_DEFAULT
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_wr_en,
   input  logic             in_rd_en,
   input  logic [1:0]       in_addr,
   input  logic [7:0]       in_wdata,
   output logic             out_ack,
   output logic [7:0]       out_rdata,
   output logic [LED_W-1:0] out_led
);

   led_mode_t        mode_q, mode_d;
   logic [LED_W-1:0] pattern_q, pattern_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [LED_W-1:0] work_q, work_d;
   logic             phase_q, phase_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             ack_q, ack_d;
   logic [7:0]       rdata_q, rdata_d;

   logic tick;
   logic div_clr;
   logic reload;

   led_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .in_div   (div_q),
      .in_clr   (div_clr),
      .out_tick (tick)
   );

   always_comb begin
      mode_d    = mode_q;
      pattern_d = pattern_q;
      div_d     = div_q;
      work_d    = work_q;
      phase_d   = phase_q;
      rdata_d   = '0;
      div_clr   = 1'b0;
      reload    = 1'b0;
      ack_d     = in_wr_en | in_rd_en;

      // A write takes priority; a read in the same cycle is dropped.
      if (in_wr_en) begin
         case (in_addr)
            ADDR_CTRL: begin
               mode_d = led_mode_t'(in_wdata[1:0]);
               reload = 1'b1;
            end
            ADDR_PAT: begin
               pattern_d = in_wdata[LED_W-1:0];
               reload    = 1'b1;
            end
            ADDR_DIV_LO: begin
               div_d[7:0] = in_wdata;
               div_clr    = 1'b1;
            end
            default: begin
               div_d[15:8] = in_wdata;
               div_clr     = 1'b1;
            end
         endcase
      end else if (in_rd_en) begin
         case (in_addr)
            ADDR_CTRL:   rdata_d = 8'(mode_q);
            ADDR_PAT:    rdata_d = 8'(pattern_q);
            ADDR_DIV_LO: rdata_d = div_q[7:0];
            default:     rdata_d = div_q[15:8];
         endcase
      end

      // Restarting the animation beats a coincident tick.
      if (reload) begin
         work_d  = pattern_d;
         phase_d = 1'b1;
      end else if (tick) begin
         case (mode_q)
            LED_BLINK: phase_d = ~phase_q;
            LED_CHASE: work_d  = {work_q[LED_W-2:0], work_q[LED_W-1]};
            default:   ;
         endcase
      end

      case (mode_q)
         LED_STATIC: led_d = pattern_q;
         LED_BLINK:  led_d = phase_q ? pattern_q : '0;
         LED_CHASE:  led_d = work_q;
         default:    led_d = '0;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         mode_q    <= LED_OFF;
         pattern_q <= '0;
         div_q     <= DIV_W'(DIV_RST);
         work_q    <= '0;
         phase_q   <= 1'b1;
         led_q     <= '0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         mode_q    <= mode_d;
         pattern_q <= pattern_d;
         div_q     <= div_d;
         work_q    <= work_d;
         phase_q   <= phase_d;
         led_q     <= led_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
      end
   end

   assign out_ack   = ack_q;
   assign out_rdata = rdata_q;
   assign out_led   = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed and randomized checks of led_pattern_ctrl against a behavioural model.
module tb_led_pattern_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic       rd_en;
   logic [1:0] addr;
   logic [7:0] wdata;
   logic       ack;
   logic [7:0] rdata;
   logic [5:0] led;

   int errors = 0;
   int checks = 0;

   // Behavioural model state (values as seen after the most recent edge).
   int m_mode, m_pat, m_div, m_cnt, m_work, m_phase;
   int m_led, m_ack, m_rdata;

   always #5 clk = ~clk;

   led_pattern_ctrl #(
      .LED_W   (6),
      .DIV_W   (16),
      .DIV_RST (49999)
   ) dut (
      .in_clk    (clk),
      .in_rst_n  (rst_n),
      .in_wr_en  (wr_en),
      .in_rd_en  (rd_en),
      .in_addr   (addr),
      .in_wdata  (wdata),
      .out_ack   (ack),
      .out_rdata (rdata),
      .out_led   (led)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_show();
      case (m_mode)
         1:       return m_pat;
         2:       return m_phase ? m_pat : 0;
         3:       return m_work;
         default: return 0;
      endcase
   endfunction

   function automatic int model_reg(input int a);
      case (a)
         0:       return m_mode;
         1:       return m_pat;
         2:       return m_div % 256;
         default: return m_div / 256;
      endcase
   endfunction

   task automatic model_edge(input bit r, input bit w, input bit rd, input int a, input int d);
      bit div_wr, tick, restart;
      if (!r) begin
         m_mode = 0; m_pat = 0; m_div = 49999; m_cnt = 0; m_work = 0; m_phase = 1;
         m_led = 0; m_ack = 0; m_rdata = 0;
         return;
      end
      div_wr  = w && (a >= 2);
      tick    = (m_cnt == m_div) && !div_wr;
      restart = w && (a <= 1);
      m_led   = model_show();
      m_ack   = (w || rd) ? 1 : 0;
      m_rdata = (rd && !w) ? model_reg(a) : 0;
      if (w) begin
         case (a)
            0:       m_mode = d % 4;
            1:       m_pat  = d % 64;
            2:       m_div  = (m_div / 256) * 256 + d;
            default: m_div  = d * 256 + (m_div % 256);
         endcase
      end
      if (div_wr || tick) m_cnt = 0;
      else                m_cnt = m_cnt + 1;
      if (restart) begin
         m_work  = m_pat;
         m_phase = 1;
      end else if (tick) begin
         if (m_mode == 2) m_phase = 1 - m_phase;
         if (m_mode == 3) m_work = (m_work * 2) % 64 + m_work / 32;
      end
   endtask

   // Drive one cycle's inputs, take the edge, then return on the falling edge.
   task automatic step(input bit r, input bit w, input bit rd, input int a, input int d);
      rst_n = r;
      wr_en = w;
      rd_en = rd;
      addr  = 2'(a);
      wdata = 8'(d);
      @(posedge clk);
      model_edge(r, w, rd, a, d);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 0);
   endtask

   task automatic write(input int a, input int d);
      step(1, 1, 0, a, d);
   endtask

   task automatic read(input int a);
      step(1, 0, 1, a, 0);
   endtask

   initial begin
      int e;
      logic [7:0] chase_exp [6];
      chase_exp = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h21};

      // Reset held two clocks.
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("rst_led", led, 0);
      check("rst_ack", ack, 0);
      check("rst_rdata", rdata, 0);
      read(2);
      check("rst_div_lo_ack", ack, 1);
      check("rst_div_lo", rdata, 8'h4F);
      read(3);
      check("rst_div_hi", rdata, 8'hC3);

      // Static mode.
      write(1, 8'h15);
      check("pat_wr_ack", ack, 1);
      write(0, 1);
      check("ctrl_wr_ack", ack, 1);
      check("static_led_early", led, 0);
      idle();
      check("static_ack_drop", ack, 0);
      check("static_led", led, 8'h15);

      // Chase with period 4, full wrap.
      write(2, 3);
      write(3, 0);
      write(1, 8'h21);
      write(0, 3);
      idle();
      check("chase_load0", led, 8'h21);
      idle();
      check("chase_load1", led, 8'h21);
      for (int k = 0; k < 6; k++) begin
         idle();
         check($sformatf("chase_step%0d", k), led, 32'(chase_exp[k]));
         idle();
         idle();
         idle();
         check($sformatf("chase_hold%0d", k), led, 32'(chase_exp[k]));
      end

      // Blink every clock, then a PATTERN write landing on a tick.
      write(2, 0);
      write(1, 8'h3F);
      write(0, 2);
      idle();
      check("blink_a", led, 8'h3F);
      idle();
      check("blink_b", led, 8'h00);
      idle();
      check("blink_c", led, 8'h3F);
      idle();
      check("blink_d", led, 8'h00);
      write(1, 8'h3F);
      idle();
      check("blink_wr_no_toggle", led, 8'h3F);
      idle();
      check("blink_resume", led, 8'h00);

      // Simultaneous write and read, then back-to-back reads.
      step(1, 1, 1, 1, 8'hEA);
      check("wr_rd_ack", ack, 1);
      check("wr_rd_rdata", rdata, 0);
      idle();
      check("wr_rd_single_ack", ack, 0);
      read(0);
      check("rd0_ack", ack, 1);
      check("rd0", rdata, 8'h02);
      read(1);
      check("rd1_ack", ack, 1);
      check("rd1", rdata, 8'h2A);
      read(2);
      check("rd2_ack", ack, 1);
      check("rd2", rdata, 8'h00);
      read(3);
      check("rd3_ack", ack, 1);
      check("rd3", rdata, 8'h00);
      idle();
      check("rd_idle_ack", ack, 0);
      check("rd_idle_rdata", rdata, 0);

      // Reset in the middle of a chase, then time the first tick.
      write(2, 1);
      write(1, 8'h05);
      write(0, 3);
      idle();
      idle();
      idle();
      step(0, 0, 0, 0, 0);
      check("midrst_led", led, 0);
      check("midrst_ack", ack, 0);
      read(0);
      check("midrst_mode", rdata, 0);
      write(1, 1);
      write(0, 3);
      read(2);
      check("midrst_div_lo", rdata, 8'h4F);
      read(3);
      check("midrst_div_hi", rdata, 8'hC3);
      check("midrst_chase_start", led, 1);
      e = 5;
      while (led == 6'd1 && e < 60000) begin
         idle();
         e++;
      end
      check("midrst_first_tick_edge", e, 50001);
      check("midrst_first_tick_led", led, 2);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int sel, a, d;
         bit r;
         r   = ($urandom_range(0, 399) != 0);
         sel = $urandom_range(0, 3);
         a   = $urandom_range(0, 3);
         if (a == 3)      d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : 0;
         else if (a == 2) d = $urandom_range(0, 6);
         else             d = $urandom_range(0, 255);
         step(r, sel[0], sel[1], a, d);
         check("rnd_led", led, 32'(m_led));
         check("rnd_ack", ack, 32'(m_ack));
         check("rnd_rdata", rdata, 32'(m_rdata));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
